reg_ext_decoder: RTL and testbench
==================================

REG_EXT_DECODER -- requirements
Module: reg_ext_decoder

Interface
REQ-001 Parameter FW, default 2: width of the short register fields in_rd and in_rp.
REQ-002 Parameter PW, default 2: prefix width; AW = FW+PW is the extended index width, derived and not overridable.
REQ-003 Parameter RD_PFX_RST, default 2'b11 (PW bits): Rd prefix after reset.
REQ-004 Parameter RP_PFX_RST, default 2'b10 (PW bits): Rp prefix after reset.
REQ-005 clk  input  1: single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1: asynchronous, active-low reset.
REQ-007 in_valid  input  1: decode request present.
REQ-008 in_ready  output  1: request accepted this cycle when in_valid is also high.
REQ-009 in_rd  input  FW: destination register field.
REQ-010 in_rp  input  FW: source register field.
REQ-011 out_valid  output  1: extended pair held in the output register.
REQ-012 out_ready  input  1: consumer takes the pair when out_valid is high.
REQ-013 out_ext_rd  output  AW: registered {rd_pfx, in_rd}.
REQ-014 out_ext_rp  output  AW: registered {rp_pfx, in_rp}.
REQ-015 cfg_we  input  1: prefix write strobe.
REQ-016 cfg_sel  input  1: 0 selects the Rd prefix, 1 selects the Rp prefix.
REQ-017 cfg_pfx  input  PW: new prefix value.
REQ-018 wb_valid  input  1: write-back complete; clears the busy bit for wb_addr.
REQ-019 wb_addr  input  AW: extended index being released.
REQ-020 flush  input  1: synchronous discard of the output register and all busy bits.
REQ-021 sb_busy  output  2^AW: scoreboard busy vector; bit i set means index i has a write in flight.

Function
REQ-022 Combinational decode SHALL compute ext_rd_c = {rd_pfx, in_rd} and ext_rp_c = {rp_pfx, in_rp} from the current prefix registers.
REQ-023 The effective busy bit of index i SHALL be sb_busy[i] AND NOT (wb_valid AND wb_addr==i), giving same-cycle write-back bypass.
REQ-024 A hazard SHALL exist when the effective busy bit of ext_rp_c (RAW) or of ext_rd_c (WAW) is set.
REQ-025 in_ready SHALL equal (NOT out_valid OR out_ready) AND NOT hazard AND NOT flush.
REQ-026 On accept (in_valid AND in_ready), the output register SHALL load ext_rd_c/ext_rp_c and set out_valid at the next edge; latency is 1 cycle.
REQ-027 When out_valid is high, out_ext_rd/out_ext_rp SHALL hold stable until out_ready is high.
REQ-028 Drain without accept (out_valid AND out_ready AND NOT accept) SHALL clear out_valid at the next edge.
REQ-029 Drain and accept in the same cycle SHALL reload the register with no bubble, giving 1 pair per cycle throughput.
REQ-030 On accept, sb_busy[ext_rd_c] SHALL be set at the next edge; if wb_valid targets the same index in that cycle, the set SHALL win.
REQ-031 wb_valid SHALL clear sb_busy[wb_addr] at the next edge; a clear of an already-clear bit SHALL have no effect.
REQ-032 cfg_we SHALL update the selected prefix at the next edge; an accept in the same cycle SHALL use the old prefix.
REQ-033 cfg_we SHALL NOT affect in_ready, the output register or sb_busy.
REQ-034 flush SHALL clear out_valid and all sb_busy bits at the next edge, with priority over accept, set and clear; prefixes SHALL be unchanged.
REQ-035 When out_valid is low, out_ext_rd/out_ext_rp SHALL retain their last value.

Reset
REQ-036 While rst_n is low, all state SHALL take reset values immediately: out_valid=0, out_ext_rd=0, out_ext_rp=0, sb_busy=0, rd_pfx=RD_PFX_RST, rp_pfx=RP_PFX_RST.
REQ-037 Reset asserted mid-transfer SHALL discard the pending pair with no partial output.
REQ-038 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-039 Defaults, in_rd=00, in_rp=10, out_ready=1 -> next cycle out_ext_rd=1100, out_ext_rp=1010, sb_busy[12]=1.
REQ-040 After REQ-039, request in_rd=01, in_rp=00 (ext_rp=1000 not busy) -> accepted; sb_busy[12] and sb_busy[13] set.
REQ-041 sb_busy[13]=1, request in_rp such that ext_rp=1101 -> in_ready=0 until wb_valid with wb_addr=1101; accepted in the wb_valid cycle via bypass.
REQ-042 out_ready=0 while out_valid=1 -> outputs held stable, in_ready=0; out_ready=1 with a new request -> back-to-back update with no bubble.
REQ-043 cfg_we=1, cfg_sel=0, cfg_pfx=01 together with an accept of in_rd=11 -> that pair has ext_rd=1111; the next pair with in_rd=11 gives 0111.
REQ-044 flush with sb_busy nonzero and out_valid=1 -> next cycle sb_busy=0, out_valid=0; async rst_n pulse mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/reg_ext_decoder.sv
// Extends short register fields with programmable prefixes, registers the extended pair
// behind a valid/ready handshake and tracks in-flight destinations in a busy scoreboard.
module reg_ext_decoder #(
  parameter int unsigned       FW         = 2,
  parameter int unsigned       PW         = 2,
  parameter logic [PW-1:0]     RD_PFX_RST = 2'b11,
  parameter logic [PW-1:0]     RP_PFX_RST = 2'b10,
  localparam int unsigned      AW         = FW + PW,
  localparam int unsigned      NB         = 1 << AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [FW-1:0] i_in_rd,
  input  logic [FW-1:0] i_in_rp,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [AW-1:0] o_out_ext_rd,
  output logic [AW-1:0] o_out_ext_rp,
  input  logic          i_cfg_we,
  input  logic          i_cfg_sel,
  input  logic [PW-1:0] i_cfg_pfx,
  input  logic          i_wb_valid,
  input  logic [AW-1:0] i_wb_addr,
  input  logic          i_flush,
  output logic [NB-1:0] o_sb_busy
);

  logic [PW-1:0] r_rd_pfx, r_rp_pfx;
  logic          r_out_valid;
  logic [AW-1:0] r_out_ext_rd, r_out_ext_rp;
  logic [NB-1:0] r_sb_busy;

  logic [AW-1:0] w_ext_rd, w_ext_rp;
  logic [NB-1:0] w_wb_mask, w_eff_busy, w_sb_busy_d;
  logic          w_hazard, w_in_ready, w_accept;

  assign w_ext_rd = {r_rd_pfx, i_in_rd};
  assign w_ext_rp = {r_rp_pfx, i_in_rp};

  // A write-back landing this cycle releases its index for the hazard check already.
  assign w_wb_mask  = i_wb_valid ? ({{(NB-1){1'b0}}, 1'b1} << i_wb_addr) : '0;
  assign w_eff_busy = r_sb_busy & ~w_wb_mask;
  assign w_hazard   = w_eff_busy[w_ext_rp] | w_eff_busy[w_ext_rd];

  assign w_in_ready = (~r_out_valid | i_out_ready) & ~w_hazard & ~i_flush;
  assign w_accept   = i_in_valid & w_in_ready;

  // Clear before set so an accept wins over a write-back to the same index.
  always_comb begin
    w_sb_busy_d = r_sb_busy;
    if (i_flush) begin
      w_sb_busy_d = '0;
    end else begin
      w_sb_busy_d = r_sb_busy & ~w_wb_mask;
      if (w_accept) w_sb_busy_d[w_ext_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_ext_rd <= '0;
      r_out_ext_rp <= '0;
      r_sb_busy    <= '0;
      r_rd_pfx     <= RD_PFX_RST;
      r_rp_pfx     <= RP_PFX_RST;
    end else begin
      if (i_flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid  <= 1'b1;
        r_out_ext_rd <= w_ext_rd;
        r_out_ext_rp <= w_ext_rp;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_sb_busy <= w_sb_busy_d;
      if (i_cfg_we) begin
        if (i_cfg_sel) r_rp_pfx <= i_cfg_pfx;
        else           r_rd_pfx <= i_cfg_pfx;
      end
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_out_valid  = r_out_valid;
  assign o_out_ext_rd = r_out_ext_rd;
  assign o_out_ext_rp = r_out_ext_rp;
  assign o_sb_busy    = r_sb_busy;

endmodule

// File: tb/tb_reg_ext_decoder.sv
// Randomised and directed bench for reg_ext_decoder against a cycle-level reference model.
module tb_reg_ext_decoder;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  in_rd, in_rp;
  logic        out_valid, out_ready;
  logic [3:0]  out_ext_rd, out_ext_rp;
  logic        cfg_we, cfg_sel;
  logic [1:0]  cfg_pfx;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic        flush;
  logic [15:0] sb_busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit m_valid;
  int m_rd, m_rp;
  bit m_busy [16];
  int m_rd_pfx, m_rp_pfx;

  reg_ext_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_rd     (in_rd),
    .i_in_rp     (in_rp),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_ext_rd(out_ext_rd),
    .o_out_ext_rp(out_ext_rp),
    .i_cfg_we    (cfg_we),
    .i_cfg_sel   (cfg_sel),
    .i_cfg_pfx   (cfg_pfx),
    .i_wb_valid  (wb_valid),
    .i_wb_addr   (wb_addr),
    .i_flush     (flush),
    .o_sb_busy   (sb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_valid  = 0;
    m_rd     = 0;
    m_rp     = 0;
    m_rd_pfx = 3;
    m_rp_pfx = 2;
    for (int i = 0; i < 16; i++) m_busy[i] = 0;
  endfunction

  function automatic bit eff_busy(int idx);
    return m_busy[idx] && !(wb_valid && int'(wb_addr) == idx);
  endfunction

  function automatic bit model_ready();
    int er = m_rd_pfx * 4 + int'(in_rd);
    int ep = m_rp_pfx * 4 + int'(in_rp);
    return (!m_valid || out_ready) && !flush && !eff_busy(er) && !eff_busy(ep);
  endfunction

  function automatic logic [15:0] model_busy_vec();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Advance one clock, updating the model from the inputs seen before the edge.
  task automatic tick();
    bit acc = in_valid && model_ready();
    int er  = m_rd_pfx * 4 + int'(in_rd);
    int ep  = m_rp_pfx * 4 + int'(in_rp);
    @(posedge clk);
    if (flush) begin
      m_valid = 0;
      for (int i = 0; i < 16; i++) m_busy[i] = 0;
    end else begin
      if (acc) begin
        m_valid = 1;
        m_rd    = er;
        m_rp    = ep;
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (wb_valid) m_busy[wb_addr] = 0;
      if (acc) m_busy[er] = 1;
    end
    if (cfg_we) begin
      if (cfg_sel) m_rp_pfx = int'(cfg_pfx);
      else         m_rd_pfx = int'(cfg_pfx);
    end
    #1;
  endtask

  task automatic idle();
    in_valid  = 0;
    in_rd     = 0;
    in_rp     = 0;
    out_ready = 1;
    cfg_we    = 0;
    cfg_sel   = 0;
    cfg_pfx   = 0;
    wb_valid  = 0;
    wb_addr   = 0;
    flush     = 0;
  endtask

  task automatic req(input logic [1:0] rd, input logic [1:0] rp);
    in_valid = 1;
    in_rd    = rd;
    in_rp    = rp;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    #12;
    n_checks++;
    if ({out_valid, out_ext_rd, out_ext_rp, sb_busy} !== 25'd0)
      $display("FAIL reset_state: got v=%b rd=%h rp=%h busy=%h want all zero",
               out_valid, out_ext_rd, out_ext_rp, sb_busy);
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic();
    req(2'b00, 2'b10);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL first_ready: got %b want 1", in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_ext_rd !== 4'b1100 || out_ext_rp !== 4'b1010 ||
        sb_busy !== 16'h1000)
      $display("FAIL first_pair: got v=%b rd=%b rp=%b busy=%h want v=1 rd=1100 rp=1010 busy=1000",
               out_valid, out_ext_rd, out_ext_rp, sb_busy);
    else n_pass++;
    req(2'b01, 2'b00);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL second_ready: got %b want 1", in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (out_ext_rd !== 4'b1101 || out_ext_rp !== 4'b1000 || sb_busy !== 16'h3000)
      $display("FAIL second_pair: got rd=%b rp=%b busy=%h want rd=1101 rp=1000 busy=3000",
               out_ext_rd, out_ext_rp, sb_busy);
    else n_pass++;
    idle();
  endtask

  task automatic test_bypass();
    // Move the Rp prefix to 11 so in_rp=01 maps onto busy index 1101.
    cfg_we = 1; cfg_sel = 1; cfg_pfx = 2'b11;
    tick();
    idle();
    req(2'b10, 2'b01);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || in_ready !== model_ready())
        $display("FAIL raw_stall: cycle %0d got ready=%b want 0", c, in_ready);
      else n_pass++;
      tick();
    end
    wb_valid = 1; wb_addr = 4'b1101;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL wb_bypass_ready: got %b want 1", in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (out_ext_rd !== 4'b1110 || out_ext_rp !== 4'b1101 || sb_busy !== 16'h5000)
      $display("FAIL wb_bypass_pair: got rd=%b rp=%b busy=%h want rd=1110 rp=1101 busy=5000",
               out_ext_rd, out_ext_rp, sb_busy);
    else n_pass++;
    idle();
  endtask

  task automatic test_back_to_back();
    flush = 1;
    tick();
    idle();
    req(2'b00, 2'b01);
    tick();
    out_ready = 0;
    req(2'b01, 2'b10);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_ext_rd !== 4'b1100 ||
          out_ext_rp !== 4'b1101)
        $display("FAIL hold_stable: cycle %0d got ready=%b v=%b rd=%b rp=%b want 0 1 1100 1101",
                 c, in_ready, out_valid, out_ext_rd, out_ext_rp);
      else n_pass++;
      tick();
    end
    out_ready = 1;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_ext_rd !== 4'b1101 || out_ext_rp !== 4'b1110)
      $display("FAIL no_bubble_1: got v=%b rd=%b rp=%b want 1 1101 1110",
               out_valid, out_ext_rd, out_ext_rp);
    else n_pass++;
    req(2'b10, 2'b11);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_ext_rd !== 4'b1110 || out_ext_rp !== 4'b1111)
      $display("FAIL no_bubble_2: got v=%b rd=%b rp=%b want 1 1110 1111",
               out_valid, out_ext_rd, out_ext_rp);
    else n_pass++;
    idle();
  endtask

  task automatic test_cfg();
    flush = 1;
    tick();
    idle();
    cfg_we = 1; cfg_sel = 0; cfg_pfx = 2'b01;
    req(2'b11, 2'b00);
    tick();
    n_checks++;
    if (out_ext_rd !== 4'b1111) $display("FAIL cfg_old_pfx: got rd=%b want 1111", out_ext_rd);
    else n_pass++;
    idle();
    req(2'b11, 2'b01);
    tick();
    n_checks++;
    if (out_ext_rd !== 4'b0111 || out_ext_rp !== 4'b1101)
      $display("FAIL cfg_new_pfx: got rd=%b rp=%b want 0111 1101", out_ext_rd, out_ext_rp);
    else n_pass++;
    idle();
  endtask

  task automatic test_flush_reset();
    flush = 1;
    req(2'b00, 2'b00);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || sb_busy !== 16'h0 || out_ext_rd !== 4'b0111)
      $display("FAIL flush_clear: got v=%b busy=%h rd=%b want 0 0000 0111",
               out_valid, sb_busy, out_ext_rd);
    else n_pass++;
    idle();
    req(2'b10, 2'b10);
    tick();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if ({out_valid, out_ext_rd, out_ext_rp, sb_busy} !== 25'd0)
      $display("FAIL async_reset: got v=%b rd=%h rp=%h busy=%h want all zero",
               out_valid, out_ext_rd, out_ext_rp, sb_busy);
    else n_pass++;
    idle();
    @(negedge clk);
    rst_n = 1;
    req(2'b01, 2'b01);
    tick();
    n_checks++;
    if (out_ext_rd !== 4'b1101 || out_ext_rp !== 4'b1001)
      $display("FAIL reset_pfx: got rd=%b rp=%b want 1101 1001", out_ext_rd, out_ext_rp);
    else n_pass++;
    idle();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_rd     = 2'($urandom_range(0, 3));
      in_rp     = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      wb_valid  = 1'($urandom_range(0, 1));
      wb_addr   = 4'($urandom_range(0, 15));
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_sel   = 1'($urandom_range(0, 1));
      cfg_pfx   = 2'($urandom_range(0, 3));
      #1;
      n_checks++;
      if (in_ready !== model_ready()) begin
        if (errs++ < 10) $display("FAIL rand_ready: cycle %0d got %b want %b",
                                  c, in_ready, model_ready());
      end else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== m_valid || out_ext_rd !== 4'(m_rd) || out_ext_rp !== 4'(m_rp) ||
          sb_busy !== model_busy_vec()) begin
        if (errs++ < 10)
          $display("FAIL rand_state: cycle %0d got v=%b rd=%h rp=%h busy=%h want %b %h %h %h",
                   c, out_valid, out_ext_rd, out_ext_rp, sb_busy,
                   m_valid, 4'(m_rd), 4'(m_rp), model_busy_vec());
      end else n_pass++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_back_to_back();
    test_cfg();
    test_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
